// File: rtl/sha256_msg_wrapper_if.sv
// Avalon-MM slave bus between the NIOS II and the SHA-256 message wrapper.
interface sha256_msg_wrapper_if;
  logic [4:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/sha256_msg_wrapper.sv
// Message buffer and digest capture for the SHA-256 controller, driven over Avalon-MM.
// Define SHA_WRAP_IRQ_EN to add the irq output and the CTRL/STATUS bit3 IRQ_ENA.
module sha256_msg_wrapper #(
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned DIGEST_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  sha256_msg_wrapper_if.slave        avs,
  output logic                       start_out,
  input  logic                       wrapper_data_request,
  output logic                       wrapper_data_valid,
  output logic [31:0]                wrapper_data,
  input  logic                       done_in,
  input  logic [32*DIGEST_WORDS-1:0] hash_in
`ifdef SHA_WRAP_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam int unsigned PTR_W     = $clog2(NUM_WORDS) + 1;
  localparam int unsigned DIG_IDX_W = $clog2(DIGEST_WORDS);
  localparam logic [4:0]  ADDR_CTRL   = 5'h10;
  localparam logic [4:0]  ADDR_STATUS = 5'h11;
  localparam logic [4:0]  ADDR_DIG    = 5'h12;
  localparam logic [4:0]  ADDR_DIG_END = 5'(ADDR_DIG + 5'(DIGEST_WORDS));

  typedef enum logic [1:0] {ST_IDLE, ST_START_P, ST_FEED, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        msg_q    [NUM_WORDS];
  logic [31:0]        digest_q [DIGEST_WORDS];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic               done_q;
  logic               err_q;
  logic               irq_ena_c;

  logic               busy_c;
  logic               ctrl_wr_c;
  logic               start_req_c;
  logic               start_ok_c;
  logic               msg_wr_c;
  logic               capture_c;
  logic [31:0]        rdata_c;
  logic               unused_c;

  assign busy_c      = (state_q != ST_IDLE);
  assign ctrl_wr_c   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign start_req_c = ctrl_wr_c && avs.avs_writedata[0];
  assign start_ok_c  = start_req_c && !busy_c;
  assign msg_wr_c    = avs.avs_write && !avs.avs_address[4];
  assign capture_c   = (state_q == ST_WAIT) && done_in;
  assign unused_c    = ^avs.avs_writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the controller-facing handshake outputs.
  always_comb begin
    state_d            = state_q;
    start_out          = 1'b0;
    wrapper_data_valid = 1'b0;
    wrapper_data       = '0;
    case (state_q)
      ST_IDLE:    if (start_req_c) state_d = ST_START_P;
      ST_START_P: begin
        start_out = 1'b1;
        state_d   = ST_FEED;
      end
      ST_FEED: begin
        if (wrapper_data_request && (rd_ptr_q < PTR_W'(NUM_WORDS))) begin
          wrapper_data_valid = 1'b1;
          wrapper_data       = msg_q[rd_ptr_q[PTR_W-2:0]];
          if (rd_ptr_q == PTR_W'(NUM_WORDS - 1)) state_d = ST_WAIT;
        end
      end
      ST_WAIT:    if (done_in) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Buffer, pointer, flags and digest capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++)    msg_q[i]    <= '0;
      for (int unsigned i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (msg_wr_c && !busy_c) msg_q[avs.avs_address[3:0]] <= avs.avs_writedata;

      if (start_ok_c || capture_c)  rd_ptr_q <= '0;
      else if (wrapper_data_valid)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (capture_c) begin
        for (int unsigned i = 0; i < DIGEST_WORDS; i++)
          digest_q[i] <= hash_in[(DIGEST_WORDS-1-i)*32 +: 32];
      end

      // Capture beats a same-cycle clear.
      if (capture_c)                                      done_q <= 1'b1;
      else if (ctrl_wr_c && avs.avs_writedata[1])         done_q <= 1'b0;
      else if (start_ok_c)                                done_q <= 1'b0;

      if ((msg_wr_c || start_req_c) && busy_c)            err_q <= 1'b1;
      else if (ctrl_wr_c && avs.avs_writedata[2])         err_q <= 1'b0;
    end
  end

`ifdef SHA_WRAP_IRQ_EN
  logic irq_ena_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_ena_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr_c) irq_ena_q <= avs.avs_writedata[3];
      irq <= done_q && irq_ena_q;
    end
  end

  assign irq_ena_c = irq_ena_q;
`else
  assign irq_ena_c = 1'b0;
`endif

  // Read mux; unmapped addresses and CTRL read back as zero.
  always_comb begin
    rdata_c = '0;
    if (!avs.avs_address[4])
      rdata_c = msg_q[avs.avs_address[3:0]];
    else if (avs.avs_address == ADDR_STATUS)
      rdata_c = 32'({rd_ptr_q, irq_ena_c, err_q, done_q, busy_c});
    else if ((avs.avs_address >= ADDR_DIG) && (avs.avs_address < ADDR_DIG_END))
      rdata_c = digest_q[DIG_IDX_W'(avs.avs_address - ADDR_DIG)];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          avs.avs_readdata <= '0;
    else if (avs.avs_read) avs.avs_readdata <= rdata_c;
  end

endmodule
